// File: rtl/cu_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control unit: FSM states,
// opcode patterns, ALU function codes, bus/PC encodings and flag positions.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_BRCH, ST_HALT
  } state_t;

  typedef enum logic [4:0] {
    IN_ILL, IN_ADD, IN_SUB, IN_AND, IN_ORR, IN_ADDS, IN_SUBS,
    IN_ADDI, IN_SUBI, IN_ANDI, IN_ORRI, IN_LDUR, IN_STUR,
    IN_B, IN_CBZ, IN_CBNZ, IN_BCOND
  } instr_t;

  localparam logic [4:0] XZR        = 5'd31;
  localparam logic [1:0] FETCH_SIZE = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_ORR = 5'b01100;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_REL  = 2'b10;
  localparam logic [1:0] PC_BUS  = 2'b11;

  localparam logic [1:0] DBUS_ALU  = 2'b00;
  localparam logic [1:0] DBUS_REGB = 2'b01;
  localparam logic [1:0] DBUS_PC   = 2'b10;
  localparam logic [1:0] DBUS_RAM  = 2'b11;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Classify an instruction word; B.cond is always recognised here and the
  // top decides whether it is legal in the current build.
  function automatic instr_t decode_instr(input logic [31:0] ir);
    instr_t c;
    c = IN_ILL;
    if      (ir[31:21] == OP_ADD)   c = IN_ADD;
    else if (ir[31:21] == OP_SUB)   c = IN_SUB;
    else if (ir[31:21] == OP_AND)   c = IN_AND;
    else if (ir[31:21] == OP_ORR)   c = IN_ORR;
    else if (ir[31:21] == OP_ADDS)  c = IN_ADDS;
    else if (ir[31:21] == OP_SUBS)  c = IN_SUBS;
    else if (ir[31:21] == OP_LDUR)  c = IN_LDUR;
    else if (ir[31:21] == OP_STUR)  c = IN_STUR;
    else if (ir[31:22] == OP_ADDI)  c = IN_ADDI;
    else if (ir[31:22] == OP_SUBI)  c = IN_SUBI;
    else if (ir[31:22] == OP_ANDI)  c = IN_ANDI;
    else if (ir[31:22] == OP_ORRI)  c = IN_ORRI;
    else if (ir[31:26] == OP_B)     c = IN_B;
    else if (ir[31:24] == OP_CBZ)   c = IN_CBZ;
    else if (ir[31:24] == OP_CBNZ)  c = IN_CBNZ;
    else if (ir[31:24] == OP_BCOND) c = IN_BCOND;
    return c;
  endfunction

  // ALU function for the arithmetic/logic classes.
  function automatic logic [4:0] fs_of(input instr_t c);
    logic [4:0] f;
    case (c)
      IN_ADD, IN_ADDS, IN_ADDI: f = FS_ADD;
      IN_SUB, IN_SUBS, IN_SUBI: f = FS_SUB;
      IN_ORR, IN_ORRI:          f = FS_ORR;
      default:                  f = FS_AND;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/control_unit_fsm_cond_eval.sv
// B.cond condition evaluator: ARM condition code against {N,Z,C,V}.
module cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       take
);
  import cu_pkg::*;

  logic n, z, c, v;
  assign n = status[FLAG_N];
  assign z = status[FLAG_Z];
  assign c = status[FLAG_C];
  assign v = status[FLAG_V];

  // Condition decode; 1110 (AL) and 1111 both branch unconditionally.
  always_comb begin
    take = 1'b0;
    case (cond)
      4'h0:    take = z;
      4'h1:    take = !z;
      4'h2:    take = c;
      4'h3:    take = !c;
      4'h4:    take = n;
      4'h5:    take = !n;
      4'h6:    take = v;
      4'h7:    take = !v;
      4'h8:    take = c && !z;
      4'h9:    take = !(c && !z);
      4'hA:    take = (n == v);
      4'hB:    take = (n != v);
      4'hC:    take = !z && (n == v);
      4'hD:    take = !(!z && (n == v));
      default: take = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit_fsm.sv
// LEGv8-subset multi-cycle control unit driving dataPath_core.
// Build option: CU_BCOND_EN enables B.cond decode; otherwise B.cond halts.
//
// state  | meaning
// RST    | post-reset idle cycle, all outputs 0
// FETCH  | read instruction word from RAM at PC into IR
// DECODE | classify IR_out, outputs 0
// EXEC   | main execute cycle of every legal instruction
// MEM    | LDUR second cycle: RAM data onto bus, write Rt
// BRCH   | CBZ/CBNZ second cycle: test Z, update PC
// HALT   | illegal opcode seen, wait for reset
module control_unit_fsm (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR_out,
  input  logic [3:0]  status,
  output logic        w_reg,
  output logic        C0,
  output logic        mem_cs,
  output logic        mem_write_en,
  output logic        IR_load,
  output logic        status_load,
  output logic [31:0] k,
  output logic [4:0]  FS,
  output logic [1:0]  PC_FS,
  output logic [1:0]  size,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  DA,
  output logic        add_tri_sel,
  output logic [1:0]  data_tri_sel,
  output logic        PC_sel,
  output logic        B_Sel,
  output logic        halt
);
  import cu_pkg::*;

  state_t state, state_nx;
  instr_t instr_raw, instr;
  logic   bcond_take;
  logic   br_take;

  logic [4:0]  rd, rn, rm;
  logic [31:0] imm12_zx, imm9_sx, imm26_br, imm19_br;

  assign rd       = IR_out[4:0];
  assign rn       = IR_out[9:5];
  assign rm       = IR_out[20:16];
  assign imm12_zx = {20'b0, IR_out[21:10]};
  assign imm9_sx  = {{23{IR_out[20]}}, IR_out[20:12]};
  assign imm26_br = {{4{IR_out[25]}}, IR_out[25:0], 2'b00};
  assign imm19_br = {{11{IR_out[23]}}, IR_out[23:5], 2'b00};

  assign instr_raw = decode_instr(IR_out);

`ifdef CU_BCOND_EN
  assign instr = instr_raw;

  cond_eval u_cond_eval (
    .cond   (IR_out[3:0]),
    .status (status),
    .take   (bcond_take)
  );
`else
  assign instr      = (instr_raw == IN_BCOND) ? IN_ILL : instr_raw;
  assign bcond_take = 1'b0;

  logic unused_flags;
  assign unused_flags = ^{status[FLAG_N], status[FLAG_C], status[FLAG_V]};
`endif

  // CBZ branches on Z set, CBNZ on Z clear; flags were rewritten in EXEC.
  assign br_take = (instr == IN_CBZ) ? status[FLAG_Z] : !status[FLAG_Z];

  // State register; reset forces RST immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_RST;
    else        state <= state_nx;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    case (state)
      ST_RST:    state_nx = ST_FETCH;
      ST_FETCH:  state_nx = ST_DECODE;
      ST_DECODE: state_nx = (instr == IN_ILL) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        case (instr)
          IN_LDUR:         state_nx = ST_MEM;
          IN_CBZ, IN_CBNZ: state_nx = ST_BRCH;
          default:         state_nx = ST_FETCH;
        endcase
      end
      ST_MEM:    state_nx = ST_FETCH;
      ST_BRCH:   state_nx = ST_FETCH;
      ST_HALT:   state_nx = ST_HALT;
      default:   state_nx = ST_RST;
    endcase
  end

  // Control word generation from state and instruction fields.
  always_comb begin
    w_reg        = 1'b0;
    C0           = 1'b0;
    mem_cs       = 1'b0;
    mem_write_en = 1'b0;
    IR_load      = 1'b0;
    status_load  = 1'b0;
    k            = 32'd0;
    FS           = FS_AND;
    PC_FS        = PC_HOLD;
    size         = 2'b00;
    SA           = 5'd0;
    SB           = 5'd0;
    DA           = 5'd0;
    add_tri_sel  = 1'b0;
    data_tri_sel = DBUS_ALU;
    PC_sel       = 1'b0;
    B_Sel        = 1'b0;
    halt         = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_cs       = 1'b1;
        add_tri_sel  = 1'b1;
        data_tri_sel = DBUS_RAM;
        size         = FETCH_SIZE;
        IR_load      = 1'b1;
      end
      ST_EXEC: begin
        case (instr)
          IN_ADD, IN_SUB, IN_AND, IN_ORR, IN_ADDS, IN_SUBS: begin
            SA          = rn;
            SB          = rm;
            DA          = rd;
            FS          = fs_of(instr);
            C0          = (instr == IN_SUB) || (instr == IN_SUBS);
            status_load = (instr == IN_ADDS) || (instr == IN_SUBS);
            w_reg       = 1'b1;
            PC_FS       = PC_INC;
          end
          IN_ADDI, IN_SUBI, IN_ANDI, IN_ORRI: begin
            SA    = rn;
            DA    = rd;
            k     = imm12_zx;
            B_Sel = 1'b1;
            FS    = fs_of(instr);
            C0    = (instr == IN_SUBI);
            w_reg = 1'b1;
            PC_FS = PC_INC;
          end
          IN_LDUR: begin
            SA     = rn;
            k      = imm9_sx;
            B_Sel  = 1'b1;
            FS     = FS_ADD;
            mem_cs = 1'b1;
            size   = SIZE_DWORD;
          end
          IN_STUR: begin
            SA           = rn;
            SB           = rd;
            k            = imm9_sx;
            B_Sel        = 1'b1;
            FS           = FS_ADD;
            mem_cs       = 1'b1;
            mem_write_en = 1'b1;
            size         = SIZE_DWORD;
            data_tri_sel = DBUS_REGB;
            PC_FS        = PC_INC;
          end
          IN_B: begin
            k     = imm26_br;
            PC_FS = PC_REL;
          end
          IN_CBZ, IN_CBNZ: begin
            SA          = rd;
            SB          = XZR;
            FS          = FS_ORR;
            status_load = 1'b1;
          end
          IN_BCOND: begin
            k     = imm19_br;
            PC_FS = bcond_take ? PC_REL : PC_INC;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        SA           = rn;
        DA           = rd;
        k            = imm9_sx;
        B_Sel        = 1'b1;
        FS           = FS_ADD;
        mem_cs       = 1'b1;
        size         = SIZE_DWORD;
        data_tri_sel = DBUS_RAM;
        w_reg        = 1'b1;
        PC_FS        = PC_INC;
      end
      ST_BRCH: begin
        k     = imm19_br;
        PC_FS = br_take ? PC_REL : PC_INC;
      end
      ST_HALT: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Scoreboard bench for control_unit_fsm: stimulus queues per-cycle expected
// output fields, a negedge monitor pops and compares them.
module tb_control_unit_fsm;

  logic        clock, reset;
  logic [31:0] IR_out;
  logic [3:0]  status;
  logic        w_reg, C0, mem_cs, mem_write_en, IR_load, status_load;
  logic [31:0] k;
  logic [4:0]  FS, SA, SB, DA;
  logic [1:0]  PC_FS, size, data_tri_sel;
  logic        add_tri_sel, PC_sel, B_Sel, halt;

  control_unit_fsm dut (
    .clock(clock), .reset(reset), .IR_out(IR_out), .status(status),
    .w_reg(w_reg), .C0(C0), .mem_cs(mem_cs), .mem_write_en(mem_write_en),
    .IR_load(IR_load), .status_load(status_load), .k(k), .FS(FS),
    .PC_FS(PC_FS), .size(size), .SA(SA), .SB(SB), .DA(DA),
    .add_tri_sel(add_tri_sel), .data_tri_sel(data_tri_sel),
    .PC_sel(PC_sel), .B_Sel(B_Sel), .halt(halt)
  );

  typedef enum int {
    F_WREG, F_C0, F_MEMCS, F_MEMWE, F_IRLOAD, F_STLOAD, F_K, F_FS, F_PCFS,
    F_SIZE, F_SA, F_SB, F_DA, F_ADDTRI, F_DATATRI, F_BSEL, F_HALT, F_ANY
  } field_t;

  typedef struct {
    int          cyc;
    field_t      f;
    logic [31:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] fld(input field_t f);
    case (f)
      F_WREG:    return {31'b0, w_reg};
      F_C0:      return {31'b0, C0};
      F_MEMCS:   return {31'b0, mem_cs};
      F_MEMWE:   return {31'b0, mem_write_en};
      F_IRLOAD:  return {31'b0, IR_load};
      F_STLOAD:  return {31'b0, status_load};
      F_K:       return k;
      F_FS:      return {27'b0, FS};
      F_PCFS:    return {30'b0, PC_FS};
      F_SIZE:    return {30'b0, size};
      F_SA:      return {27'b0, SA};
      F_SB:      return {27'b0, SB};
      F_DA:      return {27'b0, DA};
      F_ADDTRI:  return {31'b0, add_tri_sel};
      F_DATATRI: return {30'b0, data_tri_sel};
      F_BSEL:    return {31'b0, B_Sel};
      F_HALT:    return {31'b0, halt};
      default:   return {31'b0, |{w_reg, C0, mem_cs, mem_write_en, IR_load,
                   status_load, k, FS, PC_FS, size, SA, SB, DA, add_tri_sel,
                   data_tri_sel, PC_sel, B_Sel, halt}};
    endcase
  endfunction

  // Monitor: compare every queued expectation due in the current cycle.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.cyc != cyc || fld(e.f) !== e.v) begin
        bad++;
        $display("FAIL %s cyc=%0d due=%0d got=%h want=%h",
                 e.nm, cyc, e.cyc, fld(e.f), e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ex(input int dc, input field_t f, input logic [31:0] v, input string nm);
    exp_t t;
    t.cyc = cyc + dc;
    t.f   = f;
    t.v   = v;
    t.nm  = nm;
    q.push_back(t);
  endtask

  // Issue an instruction at the start of a FETCH cycle; queue FETCH/DECODE checks.
  task automatic start(input logic [31:0] ir, input string nm);
    IR_out = ir;
    ex(0, F_IRLOAD,  1, {nm, "_f_irload"});
    ex(0, F_MEMCS,   1, {nm, "_f_memcs"});
    ex(0, F_SIZE,    2, {nm, "_f_size"});
    ex(0, F_DATATRI, 3, {nm, "_f_dtri"});
    ex(0, F_ADDTRI,  1, {nm, "_f_atri"});
    ex(0, F_WREG,    0, {nm, "_f_wreg"});
    ex(1, F_ANY,     0, {nm, "_dec_zero"});
  endtask

  // Reset from the start of a cycle: one reset cycle, one RST cycle, then FETCH.
  task automatic do_reset(input string nm);
    reset = 1'b0;
    ex(0, F_ANY,  0, {nm, "_rst_any"});
    ex(0, F_HALT, 0, {nm, "_rst_halt"});
    tick();
    reset = 1'b1;
    ex(0, F_IRLOAD, 0, {nm, "_rstcyc_irload"});
    ex(0, F_ANY,    0, {nm, "_rstcyc_any"});
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d want=finish", cyc);
    $fatal(1);
  end

  initial begin
    reset  = 1'b0;
    IR_out = 32'd0;
    status = 4'd0;
    tick();
    do_reset("init");

    // ADDI X1,X0,#5
    start({10'b1001000100, 12'd5, 5'd0, 5'd1}, "addi");
    ex(2, F_SA, 0, "addi_sa");     ex(2, F_DA, 1, "addi_da");
    ex(2, F_K, 5, "addi_k");       ex(2, F_FS, 5'b01000, "addi_fs");
    ex(2, F_BSEL, 1, "addi_bsel"); ex(2, F_WREG, 1, "addi_wreg");
    ex(2, F_PCFS, 1, "addi_pcfs"); ex(2, F_STLOAD, 0, "addi_stl");
    ticks(3);

    // ADDS X3,X1,X2
    start({11'b10101011000, 5'd2, 6'd0, 5'd1, 5'd3}, "adds");
    ex(2, F_SA, 1, "adds_sa");     ex(2, F_SB, 2, "adds_sb");
    ex(2, F_DA, 3, "adds_da");     ex(2, F_FS, 5'b01000, "adds_fs");
    ex(2, F_BSEL, 0, "adds_bsel"); ex(2, F_STLOAD, 1, "adds_stl");
    ex(2, F_C0, 0, "adds_c0");     ex(2, F_WREG, 1, "adds_wreg");
    ticks(3);

    // SUB X5,X6,X7
    start({11'b11001011000, 5'd7, 6'd0, 5'd6, 5'd5}, "sub");
    ex(2, F_FS, 5'b01001, "sub_fs"); ex(2, F_C0, 1, "sub_c0");
    ex(2, F_STLOAD, 0, "sub_stl");   ex(2, F_DA, 5, "sub_da");
    ex(2, F_PCFS, 1, "sub_pcfs");
    ticks(3);

    // ORRI X8,X9,#0xABC
    start({10'b1011001000, 12'hABC, 5'd9, 5'd8}, "orri");
    ex(2, F_FS, 5'b01100, "orri_fs"); ex(2, F_K, 32'h00000ABC, "orri_k");
    ex(2, F_SA, 9, "orri_sa");        ex(2, F_DA, 8, "orri_da");
    ticks(3);

    // LDUR X4,[X31,#8]
    start({11'b11111000010, 9'd8, 2'b00, 5'd31, 5'd4}, "ldur");
    ex(2, F_SA, 31, "ldur_sa");      ex(2, F_K, 8, "ldur_k");
    ex(2, F_FS, 5'b01000, "ldur_fs"); ex(2, F_ADDTRI, 0, "ldur_atri");
    ex(2, F_MEMCS, 1, "ldur_memcs"); ex(2, F_WREG, 0, "ldur_wreg0");
    ex(2, F_PCFS, 0, "ldur_pcfs0");
    ex(3, F_DATATRI, 3, "ldur_mem_dtri"); ex(3, F_DA, 4, "ldur_mem_da");
    ex(3, F_WREG, 1, "ldur_mem_wreg");    ex(3, F_PCFS, 1, "ldur_mem_pcfs");
    ex(3, F_SIZE, 3, "ldur_mem_size");    ex(3, F_ADDTRI, 0, "ldur_mem_atri");
    ticks(4);

    // STUR X4,[X31,#-16]
    start({11'b11111000000, 9'h1F0, 2'b00, 5'd31, 5'd4}, "stur");
    ex(2, F_MEMWE, 1, "stur_we");       ex(2, F_K, 32'hFFFFFFF0, "stur_k");
    ex(2, F_SB, 4, "stur_sb");          ex(2, F_DATATRI, 1, "stur_dtri");
    ex(2, F_PCFS, 1, "stur_pcfs");      ex(2, F_WREG, 0, "stur_wreg");
    ex(2, F_ADDTRI, 0, "stur_atri");
    ex(3, F_MEMWE, 0, "stur_we_after");
    ticks(3);

    // B #-1
    start({6'b000101, 26'h3FFFFFF}, "b");
    ex(2, F_PCFS, 2, "b_pcfs"); ex(2, F_K, 32'hFFFFFFFC, "b_k");
    ticks(3);

    // CBZ X2,#-2 with X2 == 0 (Z set by EXEC)
    status = 4'b0100;
    start({8'b10110100, 19'h7FFFE, 5'd2}, "cbz_t");
    ex(2, F_SA, 2, "cbz_sa");          ex(2, F_SB, 31, "cbz_sb");
    ex(2, F_FS, 5'b01100, "cbz_fs");   ex(2, F_STLOAD, 1, "cbz_stl");
    ex(2, F_PCFS, 0, "cbz_ex_pcfs");
    ex(3, F_PCFS, 2, "cbz_t_pcfs");    ex(3, F_K, 32'hFFFFFFF8, "cbz_t_k");
    ticks(4);

    // CBZ X2,#-2 with X2 == 3
    status = 4'b0000;
    start({8'b10110100, 19'h7FFFE, 5'd2}, "cbz_n");
    ex(3, F_PCFS, 1, "cbz_n_pcfs");
    ticks(4);

    // CBNZ X2,#4 with X2 != 0
    status = 4'b0000;
    start({8'b10110101, 19'd4, 5'd2}, "cbnz");
    ex(3, F_PCFS, 2, "cbnz_pcfs"); ex(3, F_K, 32'd16, "cbnz_k");
    ticks(4);

`ifdef CU_BCOND_EN
    // B.GT #3, N=Z=V=0: taken
    status = 4'b0000;
    start({8'b01010100, 19'd3, 1'b0, 4'hC}, "bgt_t");
    ex(2, F_PCFS, 2, "bgt_t_pcfs"); ex(2, F_K, 32'd12, "bgt_t_k");
    ticks(3);
    // B.GT with Z=1: not taken
    status = 4'b0100;
    start({8'b01010100, 19'd3, 1'b0, 4'hC}, "bgt_n");
    ex(2, F_PCFS, 1, "bgt_n_pcfs");
    ticks(3);
    // B.LT with N=1,V=0: taken
    status = 4'b1000;
    start({8'b01010100, 19'd3, 1'b0, 4'hB}, "blt_t");
    ex(2, F_PCFS, 2, "blt_t_pcfs");
    ticks(3);
`else
    // B.GT is illegal in this build
    status = 4'b0000;
    start({8'b01010100, 19'd3, 1'b0, 4'hC}, "bgt_ill");
    ex(2, F_HALT, 1, "bgt_ill_halt"); ex(2, F_PCFS, 0, "bgt_ill_pcfs");
    ticks(3);
    do_reset("bgt_ill");
`endif

    // Illegal opcode 0x00000000
    start(32'h00000000, "ill");
    ex(2, F_HALT, 1, "ill_halt");   ex(2, F_PCFS, 0, "ill_pcfs");
    ex(2, F_WREG, 0, "ill_wreg");   ex(2, F_IRLOAD, 0, "ill_irload");
    ex(3, F_HALT, 1, "ill_halt_held"); ex(3, F_PCFS, 0, "ill_pcfs_held");
    ticks(4);
    do_reset("ill");

    // ADD X3,X1,X2 with reset asserted mid-EXEC
    start({11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3}, "add_rst");
    ex(2, F_ANY, 0, "add_rst_any"); ex(2, F_WREG, 0, "add_rst_wreg");
    ticks(2);
    #2 reset = 1'b0;
    tick();
    ex(0, F_ANY, 0, "add_rst_hold_any");
    reset = 1'b1;
    ex(0, F_IRLOAD, 0, "add_rst_rstcyc");
    tick();

    // Recovery: ORR X1,X2,X3 runs normally after reset
    start({11'b10101010000, 5'd3, 6'd0, 5'd2, 5'd1}, "orr");
    ex(2, F_FS, 5'b01100, "orr_fs"); ex(2, F_WREG, 1, "orr_wreg");
    ex(2, F_DA, 1, "orr_da");
    ticks(3);
    ex(0, F_IRLOAD, 1, "orr_next_fetch");
    ticks(2);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
